i2c_cmd_arbiter: RTL



---
 rtl/i2c_cmd_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C master command port among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES clocks.
module i2c_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int OW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   reqValid,
  input  logic [NREQ-1:0]   reqRw,
  input  logic [7*NREQ-1:0] reqAddr,
  input  logic [8*NREQ-1:0] reqDin,
  output logic [NREQ-1:0]   reqReady,
  output logic [NREQ-1:0]   rspValid,
  output logic [7:0]        rspDout,
  output logic              rspAckErr,
  output logic              rspTimeout,
  output logic [OW-1:0]     owner,
  output logic              arbBusy,
  output logic              mRw,
  output logic [6:0]        mAddr,
  output logic [7:0]        mDin,
  output logic              mDataValid,
  input  logic [7:0]        mDout,
  input  logic              mBusy,
  input  logic              mAckErr,
  input  logic              mDone
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          r_state, w_next;
  logic [OW-1:0]   r_ptr, r_owner, w_gnt;
  logic            r_rw, r_ackerr, w_found, w_tmo;
  logic [6:0]      r_addr;
  logic [7:0]      r_din, r_dout;
  logic            w_unused;
  logic [NREQ-1:0] w_onehot;
  assign w_unused = mBusy;
  assign w_onehot = NREQ'(1) << r_owner;
  // First requester at or after ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_ptr;
    for (int k = 0; k < NREQ; k++)
      if (!w_found && reqValid[OW'((int'(r_ptr) + k) % NREQ)]) begin
        w_found = 1'b1;
        w_gnt   = OW'((int'(r_ptr) + k) % NREQ);
      end
  end
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_tmo;
  assign w_tmo      = !mDone && r_cnt == 16'(TIMEOUT_CYCLES - 1);
  assign rspTimeout = r_state == RESP && r_tmo;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= r_state == WAIT ? r_cnt + 16'd1 : '0;
      if (r_state == WAIT && (mDone || w_tmo)) r_tmo <= !mDone;
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign rspTimeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_found ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (mDone || w_tmo) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_dout   <= '0;
      r_ackerr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        r_owner <= w_gnt;
        r_rw    <= reqRw[w_gnt];
        r_addr  <= reqAddr[7*w_gnt +: 7];
        r_din   <= reqDin[8*w_gnt +: 8];
      end
      if (r_state == WAIT && (mDone || w_tmo)) begin
        r_dout   <= (mDone && r_rw) ? mDout : '0;
        r_ackerr <= mDone ? mAckErr : 1'b1;
      end
      if (r_state == RESP) r_ptr <= r_owner == OW'(NREQ - 1) ? '0 : r_owner + 1'b1;
    end
  end
  assign owner      = r_owner;
  assign arbBusy    = r_state != IDLE;
  assign mRw        = r_rw;
  assign mAddr      = r_addr;
  assign mDin       = r_din;
  assign mDataValid = r_state == ISSUE;
  assign reqReady   = r_state == ISSUE ? w_onehot : '0;
  assign rspValid   = r_state == RESP ? w_onehot : '0;
  assign rspDout    = r_state == RESP ? r_dout : '0;
  assign rspAckErr  = r_state == RESP && r_ackerr;
endmodule
